// File: rtl/fpu_ss_pkg.sv
// Shared types and defaults for the FPU subsystem writeback path.
// wb_req_t is one register-file write request (destination plus data).
package fpu_ss_pkg;

  localparam int FPU_SS_LSU_WB_DEPTH = 2;
  localparam int FPU_SS_MAX_STARVE   = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/fpu_ss_wb_arbiter_if.sv
// Bundle of the FPnew result, LSU result, FP register-file write and XIF result signals.
// slave is the arbiter's view; master is the surrounding pipeline's view.
interface fpu_ss_wb_arbiter_if;

  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic        fpu_rd_is_fp_i;
  logic [4:0]  fpu_rd_i;
  logic [31:0] fpu_data_i;
  logic [3:0]  fpu_id_i;

  logic        lsu_valid_i;
  logic        lsu_we_i;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;

  logic        fpr_we_o;
  logic [4:0]  fpr_waddr_o;
  logic [31:0] fpr_wdata_o;
  logic        fpr_src_lsu_o;

  logic        x_result_valid_o;
  logic        x_result_ready_i;
  logic [3:0]  x_result_id_o;
  logic [4:0]  x_result_rd_o;
  logic [31:0] x_result_data_o;

  logic        lsu_buf_full_o;

  modport slave (
    input  fpu_valid_i, fpu_rd_is_fp_i, fpu_rd_i, fpu_data_i, fpu_id_i,
    input  lsu_valid_i, lsu_we_i, lsu_rd_i, lsu_data_i,
    input  x_result_ready_i,
    output fpu_ready_o,
    output fpr_we_o, fpr_waddr_o, fpr_wdata_o, fpr_src_lsu_o,
    output x_result_valid_o, x_result_id_o, x_result_rd_o, x_result_data_o,
    output lsu_buf_full_o
  );

  modport master (
    output fpu_valid_i, fpu_rd_is_fp_i, fpu_rd_i, fpu_data_i, fpu_id_i,
    output lsu_valid_i, lsu_we_i, lsu_rd_i, lsu_data_i,
    output x_result_ready_i,
    input  fpu_ready_o,
    input  fpr_we_o, fpr_waddr_o, fpr_wdata_o, fpr_src_lsu_o,
    input  x_result_valid_o, x_result_id_o, x_result_rd_o, x_result_data_o,
    input  lsu_buf_full_o
  );

endinterface

// File: rtl/fpu_ss_wb_fifo.sv
// Small FIFO of writeback requests; head is visible combinationally, push and pop may coincide.
// The producer must not push into a full FIFO unless it pops in the same cycle.
module fpu_ss_wb_fifo
  import fpu_ss_pkg::*;
#(
  parameter int DEPTH = FPU_SS_LSU_WB_DEPTH
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  wb_req_t push_data_i,
  input  logic    pop_i,
  output wb_req_t head_o,
  output logic    empty_o,
  output logic    full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t         mem_q [DEPTH];
  wb_req_t         mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  assign head_o  = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
    if (push_i) begin
      mem_d[wptr_q] = push_data_i;
      wptr_d        = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop_i) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// Shares the FP register-file write port between FPnew and load results (0-cycle writeback),
// buffers loads that lose arbitration, and holds integer FPnew results for the XIF result channel.
module fpu_ss_wb_arbiter
  import fpu_ss_pkg::*;
#(
  parameter int LSU_DEPTH  = FPU_SS_LSU_WB_DEPTH,
  parameter int MAX_STARVE = FPU_SS_MAX_STARVE
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  fpu_ss_wb_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  logic    lsu_in, fpu_fp, buf_empty, buf_full;
  logic    gnt_lsu, gnt_fpu, push, pop;
  logic    x_hs, int_rdy, hold_load;
  wb_req_t head, lsu_req, wr_req;

  logic [SW-1:0] starve_q, starve_d;
  logic          hold_vld_q, hold_vld_d;
  logic [3:0]    hold_id_q, hold_id_d;
  logic [4:0]    hold_rd_q, hold_rd_d;
  logic [31:0]   hold_data_q, hold_data_d;

  assign lsu_in  = bus.lsu_valid_i & bus.lsu_we_i;
  assign fpu_fp  = bus.fpu_valid_i & bus.fpu_rd_is_fp_i;
  assign lsu_req = '{rd: bus.lsu_rd_i, data: bus.lsu_data_i};

  // Grants are gated by reset so the write port is quiet while reset is held.
  always_comb begin
    gnt_lsu = 1'b0;
    gnt_fpu = 1'b0;
    if (rst_ni) begin
      if (buf_full)                                        gnt_lsu = 1'b1;
      else if ((starve_q == SW'(MAX_STARVE)) && fpu_fp)    gnt_fpu = 1'b1;
      else if (!buf_empty || lsu_in)                       gnt_lsu = 1'b1;
      else if (fpu_fp)                                     gnt_fpu = 1'b1;
    end
  end

  assign pop  = gnt_lsu & ~buf_empty;
  assign push = lsu_in & ~(gnt_lsu & buf_empty);

  always_comb begin
    wr_req = '0;
    if (gnt_lsu)      wr_req = buf_empty ? lsu_req : head;
    else if (gnt_fpu) wr_req = '{rd: bus.fpu_rd_i, data: bus.fpu_data_i};
  end

  assign bus.fpr_we_o       = gnt_lsu | gnt_fpu;
  assign bus.fpr_waddr_o    = wr_req.rd;
  assign bus.fpr_wdata_o    = wr_req.data;
  assign bus.fpr_src_lsu_o  = gnt_lsu;
  assign bus.lsu_buf_full_o = buf_full;

  fpu_ss_wb_fifo #(.DEPTH(LSU_DEPTH)) u_lsu_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (lsu_req),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (buf_empty),
    .full_o      (buf_full)
  );

  always_comb begin
    starve_d = starve_q;
    if (fpu_fp && gnt_lsu) begin
      if (starve_q != SW'(MAX_STARVE)) starve_d = starve_q + 1'b1;
    end else begin
      starve_d = '0;
    end
  end

  // A held integer result may be replaced in the cycle it is handed over.
  assign x_hs      = hold_vld_q & bus.x_result_ready_i;
  assign int_rdy   = ~hold_vld_q | x_hs;
  assign hold_load = bus.fpu_valid_i & ~bus.fpu_rd_is_fp_i & int_rdy;

  assign bus.fpu_ready_o = bus.fpu_rd_is_fp_i ? gnt_fpu : int_rdy;

  always_comb begin
    hold_vld_d  = hold_vld_q & ~x_hs;
    hold_id_d   = hold_id_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    if (hold_load) begin
      hold_vld_d  = 1'b1;
      hold_id_d   = bus.fpu_id_i;
      hold_rd_d   = bus.fpu_rd_i;
      hold_data_d = bus.fpu_data_i;
    end
  end

  assign bus.x_result_valid_o = hold_vld_q;
  assign bus.x_result_id_o    = hold_id_q;
  assign bus.x_result_rd_o    = hold_rd_q;
  assign bus.x_result_data_o  = hold_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q    <= '0;
      hold_vld_q  <= 1'b0;
      hold_id_q   <= '0;
      hold_rd_q   <= '0;
      hold_data_q <= '0;
    end else begin
      starve_q    <= starve_d;
      hold_vld_q  <= hold_vld_d;
      hold_id_q   <= hold_id_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
    end
  end

endmodule

// File: doc/fpu_ss_wb_arbiter.md
# fpu_ss_wb_arbiter

Writeback arbiter for the FPU subsystem. Shares the single FP register-file write port between FPnew results and XIF memory (load) results, and drives the XIF result channel for FPnew results with an integer destination. Load results cannot be back-pressured, so they are absorbed by a small buffer. A starvation counter guarantees FPnew progress under continuous load traffic. Sits between FPnew/XIF memory-result inputs and the FP register file / `x_result` interface, replacing the fixed memory-first priority in the controller.

## Interface
- `LSU_DEPTH`, 2: load-result buffer entries (≥1).
- `MAX_STARVE`, 4: consecutive LSU wins while FPnew waits before FPnew is forced (≥1).
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `fpu_valid_i` in 1: FPnew output valid.
- `fpu_ready_o` out 1: FPnew output accepted.
- `fpu_rd_is_fp_i` in 1: result targets an FP register (else integer, goes to `x_result`).
- `fpu_rd_i` in 5: destination register.
- `fpu_data_i` in 32: result data.
- `fpu_id_i` in 4: XIF instruction id.
- `lsu_valid_i` in 1: memory result valid (no ready; must always be absorbed).
- `lsu_we_i` in 1: memory result writes an FP register (load).
- `lsu_rd_i` in 5: load destination.
- `lsu_data_i` in 32: load data.
- `fpr_we_o` out 1: FP register-file write enable.
- `fpr_waddr_o` out 5: write address.
- `fpr_wdata_o` out 32: write data.
- `fpr_src_lsu_o` out 1: the current write is from the LSU path (for scoreboard clearing).
- `x_result_valid_o` out 1: XIF result valid.
- `x_result_ready_i` in 1: XIF result ready.
- `x_result_id_o` out 4: result id.
- `x_result_rd_o` out 5: integer destination.
- `x_result_data_o` out 32: result data.
- `lsu_buf_full_o` out 1: load buffer holds `LSU_DEPTH` entries.

## Operation
- LSU candidate: the buffer head if the buffer is non-empty, else the incoming `lsu_valid_i & lsu_we_i`. Results with `lsu_we_i=0` are dropped; no write, no push.
- FPU-FP candidate: `fpu_valid_i & fpu_rd_is_fp_i`.
- Grant rule, first match wins:
  1. Buffer full → LSU.
  2. Starve counter == `MAX_STARVE` and FPU-FP candidate → FPU.
  3. LSU candidate → LSU.
  4. FPU-FP candidate → FPU.
- Granted source drives `fpr_we_o`, `fpr_waddr_o`, `fpr_wdata_o`, `fpr_src_lsu_o` in the same cycle.
- LSU grant pops the buffer head, or bypasses the incoming result when the buffer is empty.
- An incoming load that is not bypassed is pushed to the buffer. Push and pop may occur in the same cycle; the count is then unchanged.
- Starve counter:
  - Increments, saturating at `MAX_STARVE`, when the FPU-FP candidate exists and LSU is granted.
  - Clears when FPU is granted or no FPU-FP candidate exists.
- Integer FPU results go to a 1-entry hold register.
  - `fpu_ready_o` for an integer result = hold empty or XIF handshake this cycle.
  - `fpu_ready_o` for an FP result = FPU granted.
- The hold register drives the `x_result_*` outputs and clears on `x_result_valid_o & x_result_ready_i` unless it is reloaded in the same cycle.
- Invariant: no buffer overflow. A push into a full buffer is impossible by rule 1 and is asserted.

## Timing
- FP writeback: 0-cycle, combinational from inputs/buffer head to `fpr_*`.
- Integer result: `x_result_valid_o` rises 1 cycle after the FPnew handshake. Sustained throughput is 1 per cycle while `x_result_ready_i=1`.
- Buffered load: written no earlier than 1 cycle after arrival. Worst case is `LSU_DEPTH` + `MAX_STARVE` cycles under contention.
- Reset values:
  - Buffer empty; starve counter 0; hold register empty.
  - `fpr_we_o=0`, `fpr_src_lsu_o=0`, `x_result_valid_o=0`, `lsu_buf_full_o=0`.
  - `x_result_*` and `fpr_waddr_o`/`fpr_wdata_o` data outputs 0.
  - `fpu_ready_o=1` only for an integer result or a granted FP result.
- Reset mid-operation discards buffered loads and the held result.
- Buffer pointers wrap modulo `LSU_DEPTH`.

## Structure
- `fpu_ss_pkg` adds `wb_req_t` (`rd` [4:0], `data` [31:0]) and `FPU_SS_LSU_WB_DEPTH` (default for `LSU_DEPTH`).
- One sub-module, `fpu_ss_wb_fifo`: parameterised `wb_req_t` FIFO with push/pop, `empty`/`full`, and simultaneous push+pop.
- Arbitration, the starve counter and the hold register live in the top module.

## Test plan
- FPU FP result rd=3, data=0x3F800000, no LSU → `fpr_we_o=1`, waddr=3, same cycle, `fpu_ready_o=1`.
- Simultaneous FPU FP rd=4 and load rd=5 → load written (waddr=5); FPU written the next cycle, `fpu_ready_o` low for one cycle.
- Continuous loads every cycle with FPU FP pending, `MAX_STARVE=4` → 4 load writes, then FPU write in cycle 5; the load arriving in cycle 5 is buffered and written in cycle 6; no overflow.
- Two loads during FPU forced grants with `LSU_DEPTH=2` → `lsu_buf_full_o=1`, next grant is LSU regardless of counter.
- FPU integer result id=7, `x_result_ready_i=0` for 3 cycles → `x_result_valid_o` held with id 7; a second integer result gets `fpu_ready_o=0` until the handshake.
- Assert `rst_ni` low with 2 buffered loads and a held result → all outputs return to reset values asynchronously; no stale write after release.
